// File: rtl/fifo_adapter_pkg.sv
// rtl/fifo_adapter_pkg.sv - lane placement and count helpers shared by the width adapter
package fifo_adapter_pkg;

  // Lane index inside a wide word for the n-th narrow item.
  function automatic int lane_pos(input int index, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - index) : index;
  endfunction

  // A count of 0 or beyond the word size means a full word.
  function automatic int norm_count(input int count, input int ratio);
    return (count == 0 || count > ratio) ? ratio : count;
  endfunction

endpackage

// File: rtl/fifo_width_unpack.sv
// rtl/fifo_width_unpack.sv - read path: splits wide words into narrow lanes honouring the valid-lane count
module fifo_width_unpack
  import fifo_adapter_pkg::*;
#(
  parameter int lane_width = 8,
  parameter int ratio = 2,
  parameter bit msb_first = 1'b1,
  parameter int cnt_width = $clog2(ratio + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wide_valid,
  output logic                        wide_ready,
  input  logic [lane_width*ratio-1:0] wide_data,
  input  logic [cnt_width-1:0]        wide_count,
  output logic                        lane_valid,
  input  logic                        lane_ready,
  output logic [lane_width-1:0]       lane_data
);

  logic [lane_width*ratio-1:0] hold_data;
  logic [cnt_width-1:0]        idx;
  logic [cnt_width-1:0]        count;
  logic                        hold_valid;
  logic                        last_lane;
  logic                        lane_fire;
  logic                        wide_fire;

  assign last_lane  = (idx == count - cnt_width'(1));
  assign lane_fire  = hold_valid && lane_ready;
  // Refill in the same cycle the last lane leaves so words stream without a bubble.
  assign wide_ready = reset_n && (!hold_valid || (lane_fire && last_lane));
  assign wide_fire  = wide_valid && wide_ready;
  assign lane_valid = hold_valid;
  assign lane_data  = hold_data[lane_pos(int'(idx), ratio, msb_first) * lane_width +: lane_width];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data  <= '0;
      idx        <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
    end else if (wide_fire) begin
      hold_data  <= wide_data;
      count      <= cnt_width'(norm_count(int'(wide_count), ratio));
      idx        <= '0;
      hold_valid <= 1'b1;
    end else if (lane_fire) begin
      if (last_lane) begin
        hold_valid <= 1'b0;
        idx        <= '0;
      end else begin
        idx <= idx + cnt_width'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_width_adapter.sv
// rtl/fifo_width_adapter.sv - narrow-lane to wide-word pack path with flush, plus unpack read path
module fifo_width_adapter
  import fifo_adapter_pkg::*;
#(
  parameter int lane_width = 8,
  parameter int ratio = 2,
  parameter bit msb_first = 1'b1,
  parameter int cnt_width = $clog2(ratio + 1)
) (
  input  logic                        clk_core,
  input  logic                        reset_n,
  input  logic                        narrow_wr_valid,
  output logic                        narrow_wr_ready,
  input  logic [lane_width-1:0]       narrow_wr_data,
  input  logic                        flush,
  output logic                        wide_wr_valid,
  input  logic                        wide_wr_ready,
  output logic [lane_width*ratio-1:0] wide_wr_data,
  output logic [cnt_width-1:0]        wide_wr_count,
  input  logic                        wide_rd_valid,
  output logic                        wide_rd_ready,
  input  logic [lane_width*ratio-1:0] wide_rd_data,
  input  logic [cnt_width-1:0]        wide_rd_count,
  output logic                        narrow_rd_valid,
  input  logic                        narrow_rd_ready,
  output logic [lane_width-1:0]       narrow_rd_data
);

  localparam int word_width = lane_width * ratio;

  logic [word_width-1:0] acc, acc_merged, acc_next, out_data, out_data_next;
  logic [cnt_width-1:0]  fill, fill_inc, fill_next, out_count, out_count_next;
  logic                  out_valid, out_valid_next, flush_pending, flush_pending_next;
  logic                  wr_fire, completing, flush_exec, load;

  assign narrow_wr_ready = reset_n && (!out_valid || wide_wr_ready);
  assign wr_fire         = narrow_wr_valid && narrow_wr_ready;
  assign fill_inc        = fill + cnt_width'(1);
  assign completing      = wr_fire && (fill == cnt_width'(ratio - 1));
  assign flush_exec      = (flush || flush_pending) && narrow_wr_ready;

  always_comb begin
    acc_merged = acc;
    if (wr_fire)
      acc_merged[lane_pos(int'(fill), ratio, msb_first) * lane_width +: lane_width] = narrow_wr_data;
    acc_next           = acc;
    fill_next          = fill;
    out_data_next      = out_data;
    out_count_next     = out_count;
    out_valid_next     = out_valid && !wide_wr_ready;
    flush_pending_next = (flush_pending || flush) && !flush_exec;
    load               = 1'b0;
    // A completing lane wins over flush, which then has nothing left to emit.
    if (completing) begin
      load           = 1'b1;
      out_data_next  = acc_merged;
      out_count_next = cnt_width'(ratio);
    end else if (flush_exec && (wr_fire || fill != '0)) begin
      load           = 1'b1;
      out_data_next  = acc_merged;
      out_count_next = wr_fire ? fill_inc : fill;
    end else if (wr_fire) begin
      acc_next  = acc_merged;
      fill_next = fill_inc;
    end
    if (load) begin
      acc_next       = '0;
      fill_next      = '0;
      out_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      fill          <= '0;
      out_data      <= '0;
      out_count     <= '0;
      out_valid     <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      acc           <= acc_next;
      fill          <= fill_next;
      out_data      <= out_data_next;
      out_count     <= out_count_next;
      out_valid     <= out_valid_next;
      flush_pending <= flush_pending_next;
    end
  end

  assign wide_wr_valid = out_valid;
  assign wide_wr_data  = out_data;
  assign wide_wr_count = out_count;

  fifo_width_unpack #(
    .lane_width(lane_width),
    .ratio     (ratio),
    .msb_first (msb_first),
    .cnt_width (cnt_width)
  ) u_unpack (
    .clk       (clk_core),
    .reset_n   (reset_n),
    .wide_valid(wide_rd_valid),
    .wide_ready(wide_rd_ready),
    .wide_data (wide_rd_data),
    .wide_count(wide_rd_count),
    .lane_valid(narrow_rd_valid),
    .lane_ready(narrow_rd_ready),
    .lane_data (narrow_rd_data)
  );

endmodule

// File: doc/fifo_width_adapter.md
# fifo_width_adapter

Parametrised bidirectional width converter between a narrow-lane streaming interface and a wide-word FIFO interface. It is the general form of the byte/word adapter: any lane width, any lane ratio, selectable lane order, partial-word flush on the write path, and partial-word consumption on the read path. All ports use a true same-cycle valid/ready handshake. It sits between a lane-oriented client (converter serializer, command parser) and a wide core FIFO.

## Interface
- `lane_width`, 8, bits per narrow item.
- `ratio`, 2, lanes per wide word (≥2).
- `msb_first`, 1:
  - 1: the first narrow item occupies the most-significant lane.
  - 0: the first narrow item occupies the least-significant lane.
- `cnt_width`, `$clog2(ratio+1)`, width of lane-count fields (derived; do not override).

- `clk_core` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `narrow_wr_valid` in 1; `narrow_wr_ready` out 1; `narrow_wr_data` in `lane_width`: lane input.
- `flush` in 1: request emission of a partially filled write word.
- `wide_wr_valid` out 1; `wide_wr_ready` in 1; `wide_wr_data` out `lane_width*ratio`; `wide_wr_count` out `cnt_width`: assembled word plus number of valid lanes.
- `wide_rd_valid` in 1; `wide_rd_ready` out 1; `wide_rd_data` in `lane_width*ratio`; `wide_rd_count` in `cnt_width`: word plus valid lanes; 0 or >`ratio` means `ratio`.
- `narrow_rd_valid` out 1; `narrow_rd_ready` in 1; `narrow_rd_data` out `lane_width`: lane output.

## Operation
- Transfer occurs on any port only when valid && ready at a `clk_core` edge.
- **Write path (pack):**
  - Lane accumulator with a fill index 0..ratio-1, plus a wide output register.
  - `narrow_wr_ready = !wide_wr_valid || wide_wr_ready`.
  - An accepted lane is placed at position = fill index, mapped by `msb_first`.
  - When the accepted lane is lane ratio-1:
    - the word, including that lane, loads into the output register;
    - `wide_wr_count = ratio`;
    - fill index returns to 0.
- **Flush:**
  - A `flush` pulse sets a sticky `flush_pending` bit.
  - It executes on the first cycle with `narrow_wr_ready` high.
  - On execution:
    - if fill index ≠ 0, the partial word loads with `wide_wr_count` = fill index;
    - unfilled lanes are zero; filled lanes keep full-word positions;
    - fill index clears.
  - A lane accepted in the same cycle as flush execution is included in the flushed word.
  - If that lane completes the word, the full word is emitted and the flush is a no-op.
  - Flush with an empty accumulator: no-op; pending bit clears.
- **Read path (unpack):**
  - Holding register, lane index, and captured count.
  - `wide_rd_ready = !hold_valid || (narrow_rd_valid && narrow_rd_ready && last_lane)`, giving back-to-back words with no bubble.
  - `narrow_rd_valid = hold_valid`.
  - `narrow_rd_data` = lane at the current index, mapped by `msb_first`.
  - `last_lane` = (index == count-1).
  - Lanes at or beyond count are never presented.

## Timing
- Reset (async assert, sync release): accumulator, fill index, `flush_pending`, output register and holding register clear.
  - `wide_wr_valid=0`, `wide_wr_data=0`, `wide_wr_count=0`, `narrow_rd_valid=0`, `narrow_rd_data=0`.
  - Both ready outputs are forced to 0 while `reset_n` is low.
- Write latency: the completing lane accepted at edge N gives `wide_wr_valid` high after edge N.
- Write throughput: one lane per cycle sustained when `wide_wr_ready` is held high.
- Read latency: a word accepted at edge N presents its first lane after edge N.
- Read throughput: one lane per cycle, including across word boundaries.
- The two paths are fully independent. Simultaneous activity on both paths never stalls either path.
- `wide_wr_valid` stays high and `wide_wr_data` stays stable until accepted.
- `narrow_rd_data` stays stable while `narrow_rd_valid` && !`narrow_rd_ready`.

## Structure
- Shared package `fifo_adapter_pkg`:
  - `lane_pos(index, ratio, msb_first)` function for lane slice offset;
  - count-normalisation function (0/over-range → ratio).
- Sub-module `fifo_width_unpack` holds the read path.
- The pack path and flush logic stay in the top level.

## Test plan
- **Full-word pack, msb_first=1:** lane_width=8, ratio=2; push 0xAB, 0xCD back-to-back, `wide_wr_ready`=1 → one word 0xABCD, count 2, valid one cycle after the 0xCD accept.
- **Partial-word flush, msb_first=0:** ratio=4; push 0x11, 0x22, then pulse flush → word 0x00002211, count 2. A later flush with an empty accumulator produces no word.
- **Flush under stall:** ratio=4. Push 4 lanes with `wide_wr_ready`=0, so the full word stalls. Pulse flush for 1 cycle, then push one more lane 0x55. Release ready → full word, then a word with count 1 containing 0x55. `narrow_wr_ready` stays low while stalled.
- **Unpack with count:** ratio=4, msb_first=1. Feed 0x01020304 count 3, then 0xA0B0C0D0 count 0, with `narrow_rd_ready`=1 → 01, 02, 03, A0, B0, C0, D0 on consecutive cycles, no bubble.
- **Backpressure:** `narrow_rd_ready` toggles every cycle on the read path → `narrow_rd_data` holds during stalls; no lane is lost or duplicated, checked against a scoreboard over 1000 random words.
- **Reset mid-operation:** assert `reset_n` low with 1 lane accumulated and a word held → all outputs zero immediately. After release, the next push of 2 lanes yields a clean word with no residue.
